sdram_write_buffer: RTL and testbench
=====================================

# sdram_write_buffer

Parametrised, buffered successor to the single-cycle SDRAM write pass-through. It accepts write requests from the core into a DEPTH-entry FIFO and drains them onto the Avalon-MM master port one per cycle under waitrequest, so the core is stalled only when the buffer is full. It sits between the core's memory-write path and the SDRAM controller's Avalon slave.

## Interface
- ADDR_WIDTH, 25, word address width
- DATA_WIDTH, 32, data width; multiple of 8
- DEPTH, 8, FIFO entries; power of two, >= 2
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- write_n  in  1  core write request, active low
- write_address  in  ADDR_WIDTH  core write address
- write_data  in  DATA_WIDTH  core write data
- write_byteenable  in  DATA_WIDTH/8  core byte enables
- data_written_n  out  1  low = request accepted this cycle
- pending  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- idle  out  1  high when pending == 0
- avm_m0_address  out  ADDR_WIDTH  head entry address
- avm_m0_write_n  out  1  low when buffer non-empty
- avm_m0_writedata  out  DATA_WIDTH  head entry data
- avm_m0_byteenable  out  DATA_WIDTH/8  head entry byte enables
- avm_m0_waitrequest  in  1  slave stall

## Operation
- Storage: DEPTH-entry circular buffer of {address, data, byteenable}; write pointer, read pointer ($clog2(DEPTH) bits, wrap naturally) and count register.
- Push: push = !write_n && count != DEPTH. data_written_n = !push (combinational). Entry written at wptr, wptr increments.
- Pop: pop = count != 0 && !avm_m0_waitrequest. rptr increments.
- Master outputs driven from entry at rptr; avm_m0_write_n = (count == 0). Head remains stable while waitrequest high (Avalon rule).
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: push refused even if a pop occurs in the same cycle; core holds request, accepted next cycle.
- Empty: pushed entry is not bypassed; it appears on master port the following cycle.
- Ordering: strictly FIFO; no merging, no reordering.
- Reset (asserted any time, including mid-drain): all pointers and count cleared, buffered writes discarded. Reset values: avm_m0_write_n=1, pending=0, idle=1, data_written_n=1 while write_n high; address/data/byteenable outputs are don't-care while avm_m0_write_n=1.

## Timing
- Acceptance latency 0: data_written_n low in same cycle as write_n low when not full.
- Push-to-master latency: 1 cycle (entry visible after clk edge capturing it).
- Throughput: one push and one pop per cycle sustained; pending constant under simultaneous push/pop.
- Drain: N entries with waitrequest low complete in N cycles.
- pending/idle update on the clock edge following push/pop.
- Reset deassertion: synchronous to clk at the design top; block accepts a push on the first edge after release.

## Test plan
- Reset then single write 0x0000010/0xDEADBEEF/be=0xF, waitrequest=0 -> data_written_n low same cycle; next cycle avm_m0_write_n low with those values for exactly one cycle; pending 0->1->0.
- waitrequest=1, 10 back-to-back writes with DEPTH=8 -> first 8 accepted, data_written_n high for writes 9-10, pending=8; release waitrequest -> 10 writes appear in order, one per cycle after stall clears, addresses increasing.
- Full with simultaneous pop: pending=8, write_n low, waitrequest drops -> push refused that cycle, pending=7, accepted next cycle, pending returns to 8.
- Random waitrequest (50%) over 1000 writes, random byteenable -> scoreboard order and content match; head stable whenever waitrequest high.
- Wrap-around: 3*DEPTH+3 writes with continuous drain -> pointers wrap, no loss or duplication.
- Assert reset_n low mid-drain with pending=5 -> avm_m0_write_n high immediately (asynchronous), pending=0, idle=1; post-reset write is first on master port.

Source files
------------

// File: rtl/sdram_write_buffer_if.sv
// Core write-request and Avalon-MM master signals of the SDRAM write buffer.
interface sdram_write_buffer_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  // Core side
  logic                      write_n;
  logic [ADDR_WIDTH-1:0]     write_address;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_byteenable;
  logic                      data_written_n;
  logic [$clog2(DEPTH):0]    pending;
  logic                      idle;
  // Avalon-MM master side
  logic [ADDR_WIDTH-1:0]     avm_m0_address;
  logic                      avm_m0_write_n;
  logic [DATA_WIDTH-1:0]     avm_m0_writedata;
  logic [DATA_WIDTH/8-1:0]   avm_m0_byteenable;
  logic                      avm_m0_waitrequest;

  // Buffer's view: takes core requests and slave stall, drives the rest.
  modport slave (
    input  write_n, write_address, write_data, write_byteenable,
    input  avm_m0_waitrequest,
    output data_written_n, pending, idle,
    output avm_m0_address, avm_m0_write_n, avm_m0_writedata, avm_m0_byteenable
  );

  // Environment's view (core plus SDRAM controller).
  modport master (
    output write_n, write_address, write_data, write_byteenable,
    output avm_m0_waitrequest,
    input  data_written_n, pending, idle,
    input  avm_m0_address, avm_m0_write_n, avm_m0_writedata, avm_m0_byteenable
  );
endinterface

// File: rtl/sdram_write_buffer.sv
// DEPTH-entry write FIFO between the core write path and an Avalon-MM slave.
// Core is stalled only when full; head entry drains one per cycle under waitrequest.
module sdram_write_buffer #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  sdram_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + BW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] head;

  // Push/pop decode; a full buffer refuses even when a pop frees a slot this cycle.
  always_comb begin
    push = !bus.write_n && (count_q != FULL);
    pop  = (count_q != '0) && !bus.avm_m0_waitrequest;
  end

  // Next pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Control state; reset discards all buffered writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.write_address, bus.write_data, bus.write_byteenable};
  end

  assign head = mem_q[rptr_q];

  assign bus.data_written_n    = !push;
  assign bus.pending           = count_q;
  assign bus.idle              = (count_q == '0);
  assign bus.avm_m0_write_n    = (count_q == '0);
  assign bus.avm_m0_address    = head[EW-1 -: ADDR_WIDTH];
  assign bus.avm_m0_writedata  = head[BW +: DATA_WIDTH];
  assign bus.avm_m0_byteenable = head[BW-1:0];
endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed and scoreboarded checks for sdram_write_buffer.
module tb_sdram_write_buffer;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int BW = DW / 8;
  localparam int EW = AW + DW + BW;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   popped;
  logic [EW-1:0] sb [$];

  sdram_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) bus ();

  sdram_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] head_word();
    return {bus.avm_m0_address, bus.avm_m0_writedata, bus.avm_m0_byteenable};
  endfunction

  function automatic logic [DW-1:0] dat(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  function automatic logic [BW-1:0] bev(input int i);
    return BW'(i + 1);
  endfunction

  task automatic set_req(input logic wn, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
    bus.write_n          = wn;
    bus.write_address    = a;
    bus.write_data       = d;
    bus.write_byteenable = be;
  endtask

  // One cycle against the reference queue: check outputs, then advance the model.
  task automatic drive(input logic wn, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, input logic wr, output logic acc);
    logic exp_push;
    set_req(wn, a, d, be);
    bus.avm_m0_waitrequest = wr;
    #1;
    exp_push = !wn && (sb.size() < D);
    chk("m_dwn",  64'(bus.data_written_n), 64'(!exp_push));
    chk("m_pend", 64'(bus.pending), 64'(sb.size()));
    chk("m_wn",   64'(bus.avm_m0_write_n), 64'(sb.size() == 0));
    if (sb.size() != 0) chk("m_head", 64'(head_word()), 64'(sb[0]));
    if (sb.size() != 0 && !wr) begin
      void'(sb.pop_front());
      popped++;
    end
    if (exp_push) sb.push_back({a, d, be});
    acc = exp_push;
    tick();
  endtask

  initial begin
    logic acc;
    logic have_req;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [BW-1:0] rb;
    int accepted;

    vectors = 0; miscompares = 0; popped = 0;
    reset_n = 1'b0;
    set_req(1'b1, '0, '0, '0);
    bus.avm_m0_waitrequest = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_wn",   64'(bus.avm_m0_write_n), 64'd1);
    chk("rst_pend", 64'(bus.pending), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_dwn",  64'(bus.data_written_n), 64'd1);

    // Single write issued in the first cycle after reset release
    reset_n = 1'b1;
    set_req(1'b0, 25'h10, 32'hDEADBEEF, 4'hF);
    #1;
    chk("s_dwn",  64'(bus.data_written_n), 64'd0);
    chk("s_pend0", 64'(bus.pending), 64'd0);
    chk("s_wn0",  64'(bus.avm_m0_write_n), 64'd1);
    tick();
    bus.write_n = 1'b1;
    #1;
    chk("s_wn1",  64'(bus.avm_m0_write_n), 64'd0);
    chk("s_addr", 64'(bus.avm_m0_address), 64'h10);
    chk("s_data", 64'(bus.avm_m0_writedata), 64'hDEADBEEF);
    chk("s_be",   64'(bus.avm_m0_byteenable), 64'hF);
    chk("s_pend1", 64'(bus.pending), 64'd1);
    chk("s_idle1", 64'(bus.idle), 64'd0);
    chk("s_dwn1", 64'(bus.data_written_n), 64'd1);
    tick();
    #1;
    chk("s_wn2",  64'(bus.avm_m0_write_n), 64'd1);
    chk("s_pend2", 64'(bus.pending), 64'd0);
    chk("s_idle2", 64'(bus.idle), 64'd1);
    tick();

    // Fill under waitrequest
    bus.avm_m0_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b0, AW'(32'h100 + i), dat(i), bev(i));
      #1;
      chk("f_dwn",  64'(bus.data_written_n), 64'd0);
      chk("f_pend", 64'(bus.pending), 64'(i));
      tick();
    end
    // Write 9 refused while full and stalled
    set_req(1'b0, 25'h108, dat(8), bev(8));
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("full_dwn",  64'(bus.data_written_n), 64'd1);
      chk("full_pend", 64'(bus.pending), 64'd8);
      chk("full_head", 64'(bus.avm_m0_address), 64'h100);
      chk("full_wn",   64'(bus.avm_m0_write_n), 64'd0);
      tick();
    end
    // Stall drops while full: still refused this cycle
    bus.avm_m0_waitrequest = 1'b0;
    #1;
    chk("fp_dwn",  64'(bus.data_written_n), 64'd1);
    chk("fp_pend", 64'(bus.pending), 64'd8);
    tick();
    // Accepted next cycle; stall again so occupancy returns to 8
    bus.avm_m0_waitrequest = 1'b1;
    #1;
    chk("fp_dwn2",  64'(bus.data_written_n), 64'd0);
    chk("fp_pend2", 64'(bus.pending), 64'd7);
    chk("fp_head2", 64'(bus.avm_m0_address), 64'h101);
    tick();
    set_req(1'b0, 25'h109, dat(9), bev(9));
    #1;
    chk("fp_dwn3",  64'(bus.data_written_n), 64'd1);
    chk("fp_pend3", 64'(bus.pending), 64'd8);
    chk("fp_head3", 64'(bus.avm_m0_address), 64'h101);
    tick();
    bus.avm_m0_waitrequest = 1'b0;
    #1;
    chk("w10_dwn",  64'(bus.data_written_n), 64'd1);
    chk("w10_pend", 64'(bus.pending), 64'd8);
    tick();
    #1;
    chk("w10_dwn2", 64'(bus.data_written_n), 64'd0);
    chk("w10_pend2", 64'(bus.pending), 64'd7);
    chk("w10_head", 64'(bus.avm_m0_address), 64'h102);
    tick();
    // Drain remaining entries in order, one per cycle
    bus.write_n = 1'b1;
    for (int k = 3; k < 10; k++) begin
      #1;
      chk("dr_addr", 64'(bus.avm_m0_address), 64'(32'h100 + k));
      chk("dr_data", 64'(bus.avm_m0_writedata), 64'(dat(k)));
      chk("dr_be",   64'(bus.avm_m0_byteenable), 64'(bev(k)));
      chk("dr_pend", 64'(bus.pending), 64'(10 - k));
      tick();
    end
    #1;
    chk("dr_idle", 64'(bus.idle), 64'd1);
    chk("dr_wn",   64'(bus.avm_m0_write_n), 64'd1);
    tick();

    // Random waitrequest and byteenable, 1000 writes against the queue model
    accepted = 0; popped = 0; have_req = 1'b0;
    ra = '0; rd = '0; rb = '0;
    for (int c = 0; c < 20000 && accepted < 1000; c++) begin
      if (!have_req && ($urandom_range(3) != 0)) begin
        ra = AW'($urandom); rd = $urandom; rb = BW'($urandom);
        have_req = 1'b1;
      end
      drive(!have_req, ra, rd, rb, 1'($urandom_range(1)), acc);
      if (acc) begin
        have_req = 1'b0;
        accepted++;
      end
    end
    chk("rand_accepted", 64'(accepted), 64'd1000);
    for (int c = 0; c < 40 && sb.size() != 0; c++) drive(1'b1, '0, '0, '0, 1'($urandom_range(1)), acc);
    chk("rand_popped", 64'(popped), 64'd1000);

    // Wrap-around: 3*DEPTH+3 writes with continuous drain
    popped = 0;
    for (int i = 0; i < 3 * D + 3; i++)
      drive(1'b0, AW'(32'h2000 + i), dat(i + 50), bev(i), 1'b0, acc);
    for (int c = 0; c < 4; c++) drive(1'b1, '0, '0, '0, 1'b0, acc);
    chk("wrap_popped", 64'(popped), 64'(3 * D + 3));

    // Asynchronous reset mid-drain with five entries held
    for (int i = 0; i < 5; i++)
      drive(1'b0, AW'(32'h3000 + i), dat(i + 90), bev(i), 1'b1, acc);
    bus.write_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_wn",   64'(bus.avm_m0_write_n), 64'd1);
    chk("ar_pend", 64'(bus.pending), 64'd0);
    chk("ar_idle", 64'(bus.idle), 64'd1);
    sb.delete();
    tick();
    reset_n = 1'b1;
    drive(1'b0, 25'h1ABC, 32'h1234_5678, 4'h6, 1'b0, acc);
    drive(1'b1, '0, '0, '0, 1'b0, acc);
    drive(1'b1, '0, '0, '0, 1'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
